// File: rtl/alu_pkg.sv
// Shared definitions for the bit-serial ALU sequencer: RISC-V ALU-control
// codes, FSM state encoding, decoded-control struct and a legality check.
package alu_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COMPUTE = 2'd1,
      FINISH  = 2'd2
   } state_t;

   // Controls for the 1-bit slice; slt selects the Set bit as the final result.
   typedef struct packed {
      logic       ainvert;
      logic       binvert;
      logic [1:0] operation;
      logic       slt;
   } ctrl_t;

   function automatic logic legal_ctrl(input logic [3:0] code);
      logic ok;
      case (code)
         ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR: ok = 1'b1;
         default:                                             ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ALU_1bit_MSB.sv
// MSB-capable 1-bit ALU slice. Operation selects AND/OR/SUM/Less.
// Set is the sign-corrected less-than bit (sum XOR overflow) so it stays
// correct when the subtraction overflows; Overflow is carry-in XOR carry-out.
module ALU_1bit_MSB (
   input  logic       a,
   input  logic       b,
   input  logic       less,
   input  logic       ainvert,
   input  logic       binvert,
   input  logic       carry_in,
   input  logic [1:0] operation,
   output logic       result,
   output logic       carry_out,
   output logic       set,
   output logic       overflow
);

   logic ai;
   logic bi;
   logic sum;

   // Combinational bit slice: invert, full add, select.
   always_comb begin
      ai        = a ^ ainvert;
      bi        = b ^ binvert;
      sum       = ai ^ bi ^ carry_in;
      carry_out = (ai & bi) | (carry_in & (ai ^ bi));
      overflow  = carry_in ^ carry_out;
      set       = sum ^ overflow;
      case (operation)
         2'b00:   result = ai & bi;
         2'b01:   result = ai | bi;
         2'b10:   result = sum;
         default: result = less;
      endcase
   end

endmodule

// File: rtl/serial_alu_seq.sv
// Bit-serial ALU sequencer: steps one ALU_1bit_MSB slice across WIDTH bits,
// LSB first, and reports result/zero/overflow through a start/done handshake.
//
// Handshake: start is sampled only in IDLE (busy low). A start with a legal
// code is accepted on that edge; a start with an illegal code instead pulses
// err for one cycle. done pulses for exactly one cycle WIDTH+1 cycles after
// acceptance, with result/zero/overflow already valid; they hold until the
// next operation finishes. start while busy (including the done cycle) is
// ignored.
module serial_alu_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [3:0]       alu_ctrl,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             err,
   output logic [1:0]       state_dbg
);

   state_t             state_q;
   state_t             state_d;
   ctrl_t              dec;
   ctrl_t              ctrl_q;
   logic               legal;
   logic               accept;
   logic               last;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   sh_q;
   logic [CNT_W-1:0]   idx_q;
   logic               carry_q;
   logic               s_res;
   logic               s_cout;
   logic               s_set;
   logic               s_ovf;
   logic [WIDTH-1:0]   final_res;

   assign state_dbg = state_q;

   // Decode the ALU-control code into slice controls.
   always_comb begin
      dec   = '0;
      legal = legal_ctrl(alu_ctrl);
      case (alu_ctrl)
         ALU_AND: dec = '{ainvert: 1'b0, binvert: 1'b0, operation: 2'b00, slt: 1'b0};
         ALU_OR:  dec = '{ainvert: 1'b0, binvert: 1'b0, operation: 2'b01, slt: 1'b0};
         ALU_ADD: dec = '{ainvert: 1'b0, binvert: 1'b0, operation: 2'b10, slt: 1'b0};
         ALU_SUB: dec = '{ainvert: 1'b0, binvert: 1'b1, operation: 2'b10, slt: 1'b0};
         ALU_SLT: dec = '{ainvert: 1'b0, binvert: 1'b1, operation: 2'b10, slt: 1'b1};
         ALU_NOR: dec = '{ainvert: 1'b1, binvert: 1'b1, operation: 2'b00, slt: 1'b0};
         default: dec = '0;
      endcase
   end

   assign accept = (state_q == IDLE) && start && legal;
   assign last   = (idx_q == CNT_W'(WIDTH - 1));

   ALU_1bit_MSB u_slice (
      .a         (a_q[idx_q]),
      .b         (b_q[idx_q]),
      .less      (1'b0),
      .ainvert   (ctrl_q.ainvert),
      .binvert   (ctrl_q.binvert),
      .carry_in  (carry_q),
      .operation (ctrl_q.operation),
      .result    (s_res),
      .carry_out (s_cout),
      .set       (s_set),
      .overflow  (s_ovf)
   );

   // Final result as it will look once the MSB slice output is shifted in.
   always_comb begin
      final_res = {s_res, sh_q[WIDTH-1:1]};
      if (ctrl_q.slt) begin
         final_res = {{(WIDTH-1){1'b0}}, s_set};
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next-state and status outputs.
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      done    = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) state_d = COMPUTE;
         end
         COMPUTE: begin
            busy = 1'b1;
            if (last) state_d = FINISH;
         end
         FINISH: begin
            busy    = 1'b1;
            done    = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath: operand latch, serial carry/shift, output capture on the last bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         ctrl_q   <= '0;
         sh_q     <= '0;
         idx_q    <= '0;
         carry_q  <= 1'b0;
         result   <= '0;
         zero     <= 1'b0;
         overflow <= 1'b0;
         err      <= 1'b0;
      end else begin
         err <= (state_q == IDLE) && start && !legal;
         if (accept) begin
            a_q     <= a;
            b_q     <= b;
            ctrl_q  <= dec;
            sh_q    <= '0;
            idx_q   <= '0;
            carry_q <= dec.binvert;
         end else if (state_q == COMPUTE) begin
            carry_q <= s_cout;
            sh_q    <= {s_res, sh_q[WIDTH-1:1]};
            if (last) begin
               // Hold idx at the top so it never wraps; it is cleared on accept.
               result   <= final_res;
               zero     <= (final_res == '0);
               overflow <= (ctrl_q.operation == 2'b10) ? s_ovf : 1'b0;
            end else begin
               idx_q <= idx_q + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_serial_alu_seq.sv
// Directed bench for serial_alu_seq with hand-computed expected values.
module tb_serial_alu_seq;
   import alu_pkg::*;

   localparam int W = 32;

   logic          clk;
   logic          rst_n;
   logic          start;
   logic [3:0]    alu_ctrl;
   logic [W-1:0]  a;
   logic [W-1:0]  b;
   logic          busy;
   logic          done;
   logic [W-1:0]  result;
   logic          zero;
   logic          overflow;
   logic          err;
   logic [1:0]    state_dbg;

   int            n_cmp;
   int            n_bad;
   logic [W-1:0]  exp_q[$];

   serial_alu_seq #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .alu_ctrl  (alu_ctrl),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .result    (result),
      .zero      (zero),
      .overflow  (overflow),
      .err       (err),
      .state_dbg (state_dbg)
   );

   // Clock and reset.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one request on a negedge; returns after the accepting posedge + 1.
   task automatic launch(input logic [3:0] c, input logic [W-1:0] va, input logic [W-1:0] vb);
      @(negedge clk);
      alu_ctrl = c;
      a        = va;
      b        = vb;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      a     = $urandom;
      b     = $urandom;
   endtask

   // Wait for done, checking latency, busy length and outputs. If poke > 0, a
   // competing start is raised in that cycle after acceptance.
   task automatic finish_op(input string tag, input int poke, input logic exp_z, input logic exp_o);
      int lat;
      int busy_cnt;
      logic [W-1:0] exp_r;
      lat      = 0;
      busy_cnt = 0;
      exp_r    = exp_q.pop_front();
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (start) start = 1'b0;
         if (n == poke) begin
            start    = 1'b1;
            alu_ctrl = ALU_SUB;
            a        = $urandom;
            b        = $urandom;
         end
         if (busy) busy_cnt++;
         if (done) begin
            lat = n;
            break;
         end
      end
      check({tag, "_latency"}, lat, W + 1);
      check({tag, "_busy_len"}, busy_cnt, W + 1);
      check({tag, "_result"}, result, exp_r);
      check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_z});
      check({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_o});
      @(negedge clk);
      start = 1'b0;
      check({tag, "_idle_after"}, {29'd0, busy, done, err}, 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [3:0] c, input logic [W-1:0] va,
                         input logic [W-1:0] vb, input logic [W-1:0] er,
                         input logic ez, input logic eo);
      exp_q.push_back(er);
      launch(c, va, vb);
      finish_op(tag, 0, ez, eo);
   endtask

   initial begin
      n_cmp    = 0;
      n_bad    = 0;
      start    = 1'b0;
      alu_ctrl = 4'd0;
      a        = '0;
      b        = '0;
      rst_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_outputs", {25'd0, busy, done, err, zero, overflow, state_dbg}, 32'd0);
      check("reset_result", result, 32'd0);
      rst_n = 1'b1;

      run_op("add_5_7",     ALU_ADD, 32'd5,          32'd7,          32'd12,         1'b0, 1'b0);
      run_op("sub_3_5",     ALU_SUB, 32'd3,          32'd5,          32'hFFFF_FFFE,  1'b0, 1'b0);
      run_op("sub_equal",   ALU_SUB, 32'h1234,       32'h1234,       32'd0,          1'b1, 1'b0);
      run_op("add_ovf",     ALU_ADD, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  1'b0, 1'b1);
      run_op("slt_neg",     ALU_SLT, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1'b0);
      run_op("slt_ovf_a",   ALU_SLT, 32'h7FFF_FFFF,  32'h8000_0000,  32'd0,          1'b1, 1'b1);
      run_op("slt_ovf_b",   ALU_SLT, 32'h8000_0000,  32'h7FFF_FFFF,  32'd1,          1'b0, 1'b1);
      run_op("and",         ALU_AND, 32'hF0F0_F0F0,  32'hFF00_FF00,  32'hF000_F000,  1'b0, 1'b0);
      run_op("or",          ALU_OR,  32'hF0F0_F0F0,  32'hFF00_FF00,  32'hFFF0_FFF0,  1'b0, 1'b0);
      run_op("nor",         ALU_NOR, 32'd0,          32'd0,          32'hFFFF_FFFF,  1'b0, 1'b0);

      // Illegal code in IDLE: one-cycle err, no busy, result unchanged.
      @(negedge clk);
      alu_ctrl = 4'b1111;
      a        = 32'd9;
      b        = 32'd9;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("illegal_err_hi", {30'd0, err, busy}, 32'd2);
      @(negedge clk);
      check("illegal_err_lo", {30'd0, err, busy}, 32'd0);
      check("illegal_result", result, 32'hFFFF_FFFF);

      // Start during COMPUTE is ignored.
      exp_q.push_back(32'h30);
      launch(ALU_ADD, 32'h10, 32'h20);
      finish_op("busy_start", 5, 1'b0, 1'b0);

      // Start coinciding with done is ignored.
      exp_q.push_back(32'h0000_0011);
      launch(ALU_OR, 32'h0000_0001, 32'h0000_0010);
      finish_op("done_start", W + 1, 1'b0, 1'b0);

      // Reset mid-operation aborts with no done.
      launch(ALU_ADD, 32'd100, 32'd200);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midreset_flags", {25'd0, busy, done, err, zero, overflow, state_dbg}, 32'd0);
      check("midreset_result", result, 32'd0);
      begin
         int seen_done;
         seen_done = 0;
         repeat (3) begin
            @(negedge clk);
            if (done) seen_done++;
         end
         rst_n = 1'b1;
         repeat (W + 4) begin
            @(negedge clk);
            if (done || busy) seen_done++;
         end
         check("midreset_no_done", seen_done, 0);
      end

      run_op("post_reset_add", ALU_ADD, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/serial_alu_seq.md
Name: serial_alu_seq

Overview:
- Multi-cycle, bit-serial ALU sequencer; sits directly upstream of the 1-bit ALU slice and drives it.
- Accepts a RISC-V ALU-control code plus two WIDTH-bit operands and steps one slice through all bits, LSB first.
- Returns result, zero and overflow flags through a start/done handshake.
- Area-minimal EX-stage alternative to the 32-slice ripple ALU.

Parameters:
- WIDTH, 32, operand/result width in bits (>=2).
- CNT_W, $clog2(WIDTH), bit-index counter width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- alu_ctrl  in  4  0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR.
- a  in  WIDTH  operand A; latched on accepted start.
- b  in  WIDTH  operand B; latched on accepted start.
- busy  out  1  high in COMPUTE and FINISH.
- done  out  1  one-cycle pulse; result and flags valid.
- result  out  WIDTH  operation result; held until the next FINISH.
- zero  out  1  result == 0.
- overflow  out  1  signed overflow for ADD/SUB/SLT; 0 for logic ops.
- err  out  1  one-cycle pulse on start with an illegal alu_ctrl.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset (async, any state, including mid-operation):
  - State goes to IDLE.
  - busy, done, err, result, zero and overflow all go to 0.
  - Operation aborts with no done pulse.
- FSM states:
  - IDLE: on start with a legal code, latch a, b and the decoded controls (Ainvert, Binvert, Operation[1:0], slt flag). Clear idx and the shift register. Set carry = Binvert. Go to COMPUTE.
  - IDLE, illegal code: start with an illegal code pulses err for 1 cycle, state stays IDLE, result and flags are unchanged.
  - COMPUTE: each cycle, feed a[idx] and b[idx] with the latched controls and Less=0 to the slice.
    - carry <= slice CarryOut.
    - Shift register shifts right, inserting slice Result at the MSB.
    - idx increments.
    - At idx == WIDTH-1, capture Set and Overflow from the MSB slice outputs, then go to FINISH.
  - FINISH: done=1 for exactly one cycle, then go to IDLE.
- Control decode:
  - AND: Ainv 0, Binv 0, Op 00.
  - OR: Ainv 0, Binv 0, Op 01.
  - ADD: Ainv 0, Binv 0, Op 10.
  - SUB: Ainv 0, Binv 1, Op 10.
  - SLT: Ainv 0, Binv 1, Op 10 internally (subtract pass).
  - NOR: Ainv 1, Binv 1, Op 00.
- Output registers (result, zero, overflow) update on the edge entering FINISH:
  - Non-SLT: result = shift register.
  - SLT: result = {WIDTH-1 zeros, Set}, with Set = Overflow XOR MSB sum bit.
  - zero is computed from the final result.
  - overflow = MSB carry-in XOR carry-out for ADD/SUB/SLT, else 0.
- Latency: start accepted at edge k, done high during cycle k+WIDTH+1 (WIDTH compute cycles plus 1 finish cycle). Throughput is one op per WIDTH+2 cycles.
- Boundary conditions:
  - start while busy is ignored: no latch, no err.
  - start in the same cycle as done is ignored; the next start is accepted in IDLE.
  - Operand changes after acceptance have no effect.
  - Carry out of the MSB is discarded; no unsigned-carry output.
  - idx never wraps mid-operation; it is reset on each accept.

Decomposition:
- Shared package (alu_pkg):
  - 4-bit ALU-control code constants (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR).
  - FSM state encoding (IDLE, COMPUTE, FINISH).
  - Decoded-control struct {ainvert, binvert, operation[1:0], slt}.
  - Function legal_ctrl().
- One sub-module: the team's existing MSB-capable 1-bit ALU slice (ALU_1bit_MSB), instantiated once.
  - It provides Result, CarryOut, Set and Overflow.
  - The sequencer uses Set/Overflow only on the idx == WIDTH-1 cycle.
- Decode logic stays inline.

Test Plan:
- ADD a=5, b=7 -> done at k+33, result=12, zero=0, overflow=0; busy high for exactly 33 cycles.
- SUB a=3, b=5 -> result=0xFFFFFFFE, overflow=0.
- SUB a=b=0x1234 -> result=0, zero=1.
- ADD a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1.
- SLT a=0xFFFFFFFF, b=1 -> result=1.
- SLT overflow case a=0x7FFFFFFF, b=0x80000000 -> result=0, overflow=1.
- SLT overflow case a=0x80000000, b=0x7FFFFFFF -> result=1.
- AND 0xF0F0F0F0 with 0xFF00FF00 -> 0xF000F000.
- OR same operands -> 0xFFF0FFF0.
- NOR a=0, b=0 -> 0xFFFFFFFF.
- Start with alu_ctrl=1111 in IDLE -> err pulses 1 cycle, busy stays 0, result unchanged.
- Start pulse during COMPUTE -> ignored; the first op completes unaltered.
- rst_n low at compute cycle 10 -> all outputs 0 immediately, no done.
- After reset release, ADD 1+1 -> result=2 at k+33.
